usb_trsac_ctrl: RTL and testbench

USB_TRSAC_CTRL -- requirements
Module: usb_trsac_ctrl

---
 rtl/usb_trsac_pkg.sv | 31 +++
 rtl/usb_trsac_replydec.sv | 57 +++++
 rtl/usb_trsac_ctrl.sv | 163 ++++++++++++++++
 tb/tb_usb_trsac_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_trsac_pkg.sv
// Shared encodings for the USB transaction controller: token types, handshake
// replies and controller FSM states.
package usb_trsac_pkg;

  localparam int unsigned EP_W    = 4;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned REPLY_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    TT_OUT   = 2'd0,
    TT_IN    = 2'd1,
    TT_SETUP = 2'd2,
    TT_RSVD  = 2'd3
  } trsac_type_e;

  typedef enum logic [REPLY_W-1:0] {
    RP_ACK     = 2'd0,
    RP_NAK     = 2'd1,
    RP_STALL   = 2'd2,
    RP_NOREPLY = 2'd3
  } reply_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REPLY    = 3'd1,
    ST_RX       = 3'd2,
    ST_TX       = 3'd3,
    ST_WAIT_END = 3'd4
  } state_e;

endpackage

// File: rtl/usb_trsac_replydec.sv
// Handshake decision for one token: picks ACK/NAK/STALL/NOREPLY from the
// addressed endpoint, token type, device state and per-endpoint status.
module usb_trsac_replydec
  import usb_trsac_pkg::*;
#(
  parameter int unsigned NEP = 4
) (
  input  logic [EP_W-1:0]    ep,
  input  logic [TYPE_W-1:0]  trsac_type,
  input  logic               configured,
  input  logic [NEP-1:0]     ep_stall,
  input  logic [NEP-1:0]     rx_ready,
  input  logic [NEP-1:0]     tx_valid,
  output logic [REPLY_W-1:0] reply_c
);

  logic        sel_stall;
  logic        sel_rx_ready;
  logic        sel_tx_valid;
  trsac_type_e ttype;
  reply_e      reply;

  // Per-endpoint status select; endpoints beyond NEP read as zero
  always_comb begin
    sel_stall    = 1'b0;
    sel_rx_ready = 1'b0;
    sel_tx_valid = 1'b0;
    for (int unsigned i = 0; i < NEP; i++) begin
      if (ep == EP_W'(i)) begin
        sel_stall    = ep_stall[i];
        sel_rx_ready = rx_ready[i];
        sel_tx_valid = tx_valid[i];
      end
    end
  end

  always_comb begin
    ttype = trsac_type_e'(trsac_type);
    reply = RP_NOREPLY;
    if ((32'(ep) >= NEP) || (ttype == TT_RSVD)) begin
      reply = RP_NOREPLY;
    end else if (ttype == TT_SETUP) begin
      reply = (ep == '0) ? RP_ACK : RP_NOREPLY;
    end else if (!configured && (ep != '0)) begin
      reply = RP_NOREPLY;
    end else if (sel_stall) begin
      reply = RP_STALL;
    end else if (ttype == TT_OUT) begin
      reply = sel_rx_ready ? RP_ACK : RP_NAK;
    end else begin
      reply = sel_tx_valid ? RP_ACK : RP_NAK;
    end
  end

  assign reply_c = reply;

endmodule

// File: rtl/usb_trsac_ctrl.sv
// USB transaction controller: answers token requests with a handshake and
// moves packet bytes between the link FIFOs and the application.
module usb_trsac_ctrl
  import usb_trsac_pkg::*;
#(
  parameter int unsigned NEP = 4,
  parameter int unsigned DW  = 8
) (
  input  logic               clk_4xrate,
  input  logic               rst1_sync,
  input  logic               trsac_req,
  input  logic [TYPE_W-1:0]  trsac_type,
  input  logic [EP_W-1:0]    trsac_ep,
  output logic [REPLY_W-1:0] trsac_reply,
  output logic               rfifo_rd,
  input  logic               rfifo_empty,
  input  logic [DW-1:0]      rfifo_rdata,
  output logic               tfifo_wr,
  input  logic               tfifo_full,
  output logic [DW-1:0]      tfifo_wdata,
  input  logic               device_configured,
  input  logic [NEP-1:0]     ep_stall,
  input  logic [NEP-1:0]     app_rx_ready,
  output logic               app_rx_wr,
  output logic [DW-1:0]      app_rx_data,
  output logic [EP_W-1:0]    app_rx_ep,
  output logic               app_rx_setup,
  output logic               app_rx_done,
  input  logic [NEP-1:0]     app_tx_valid,
  output logic               app_tx_rd,
  input  logic [DW-1:0]      app_tx_data,
  input  logic               app_tx_last,
  output logic [EP_W-1:0]    app_tx_ep,
  output logic               app_tx_abort
);

  state_e          state_q, state_d;
  reply_e          reply_q, reply_d;
  logic [EP_W-1:0] ep_q, ep_d;
  trsac_type_e     type_q, type_d;
  logic            rx_done_q, rx_done_d;
  logic            tx_abort_q, tx_abort_d;
  logic            rx_pop_c;
  logic            tx_pop_c;
  logic [REPLY_W-1:0] dec_reply_c;

  usb_trsac_replydec #(
    .NEP (NEP)
  ) u_replydec (
    .ep         (trsac_ep),
    .trsac_type (trsac_type),
    .configured (device_configured),
    .ep_stall   (ep_stall),
    .rx_ready   (app_rx_ready),
    .tx_valid   (app_tx_valid),
    .reply_c    (dec_reply_c)
  );

  // State register
  always_ff @(posedge clk_4xrate) begin
    if (rst1_sync) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trsac_req) state_d = ST_REPLY;
      end
      ST_REPLY: begin
        if (reply_q == RP_ACK) begin
          state_d = (type_q == TT_IN) ? ST_TX : ST_RX;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      ST_RX: begin
        if (!trsac_req && rfifo_empty) state_d = ST_IDLE;
      end
      ST_TX: begin
        if (!trsac_req) begin
          state_d = ST_IDLE;
        end else if (!tfifo_full && app_tx_last) begin
          state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (!trsac_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: registered reply/latches/pulses plus combinational strobes
  always_comb begin
    reply_d    = reply_q;
    ep_d       = ep_q;
    type_d     = type_q;
    rx_done_d  = 1'b0;
    tx_abort_d = 1'b0;
    rx_pop_c   = 1'b0;
    tx_pop_c   = 1'b0;
    if (state_q != ST_IDLE && !trsac_req) reply_d = RP_NOREPLY;
    case (state_q)
      ST_IDLE: begin
        reply_d = RP_NOREPLY;
        if (trsac_req) begin
          ep_d    = trsac_ep;
          type_d  = trsac_type_e'(trsac_type);
          reply_d = reply_e'(dec_reply_c);
        end
      end
      ST_RX: begin
        rx_pop_c = !rfifo_empty;
        if (!trsac_req && rfifo_empty) rx_done_d = 1'b1;
      end
      ST_TX: begin
        // A dropped request abandons the packet without popping this cycle
        if (trsac_req) begin
          tx_pop_c = !tfifo_full;
        end else begin
          tx_abort_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_4xrate) begin
    if (rst1_sync) begin
      reply_q    <= RP_NOREPLY;
      ep_q       <= '0;
      type_q     <= TT_OUT;
      rx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
    end else begin
      reply_q    <= reply_d;
      ep_q       <= ep_d;
      type_q     <= type_d;
      rx_done_q  <= rx_done_d;
      tx_abort_q <= tx_abort_d;
    end
  end

  assign trsac_reply  = reply_q;
  assign rfifo_rd     = rx_pop_c;
  assign app_rx_wr    = rx_pop_c;
  assign app_rx_data  = rfifo_rdata;
  assign app_rx_ep    = ep_q;
  assign app_rx_setup = (type_q == TT_SETUP);
  assign app_rx_done  = rx_done_q;
  assign tfifo_wr     = tx_pop_c;
  assign app_tx_rd    = tx_pop_c;
  assign tfifo_wdata  = app_tx_data;
  assign app_tx_ep    = ep_q;
  assign app_tx_abort = tx_abort_q;

endmodule

// File: tb/tb_usb_trsac_ctrl.sv
// Directed bench for usb_trsac_ctrl with behavioural FIFO/app-source models.
module tb_usb_trsac_ctrl;

  localparam int unsigned NEP = 4;
  localparam int unsigned DW  = 8;

  logic           clk = 1'b0;
  logic           rst1_sync = 1'b1;
  logic           trsac_req = 1'b0;
  logic [1:0]     trsac_type = 2'd0;
  logic [3:0]     trsac_ep = 4'd0;
  logic [1:0]     trsac_reply;
  logic           rfifo_rd, rfifo_empty;
  logic [DW-1:0]  rfifo_rdata;
  logic           tfifo_wr;
  logic           tfifo_full = 1'b0;
  logic [DW-1:0]  tfifo_wdata;
  logic           device_configured = 1'b1;
  logic [NEP-1:0] ep_stall = '0;
  logic [NEP-1:0] app_rx_ready = '0;
  logic           app_rx_wr;
  logic [DW-1:0]  app_rx_data;
  logic [3:0]     app_rx_ep;
  logic           app_rx_setup, app_rx_done;
  logic [NEP-1:0] app_tx_valid = '0;
  logic           app_tx_rd;
  logic [DW-1:0]  app_tx_data;
  logic           app_tx_last;
  logic [3:0]     app_tx_ep;
  logic           app_tx_abort;

  always #5 clk = ~clk;

  usb_trsac_ctrl #(.NEP(NEP), .DW(DW)) dut (
    .clk_4xrate(clk), .rst1_sync(rst1_sync), .trsac_req(trsac_req),
    .trsac_type(trsac_type), .trsac_ep(trsac_ep), .trsac_reply(trsac_reply),
    .rfifo_rd(rfifo_rd), .rfifo_empty(rfifo_empty), .rfifo_rdata(rfifo_rdata),
    .tfifo_wr(tfifo_wr), .tfifo_full(tfifo_full), .tfifo_wdata(tfifo_wdata),
    .device_configured(device_configured), .ep_stall(ep_stall),
    .app_rx_ready(app_rx_ready), .app_rx_wr(app_rx_wr), .app_rx_data(app_rx_data),
    .app_rx_ep(app_rx_ep), .app_rx_setup(app_rx_setup), .app_rx_done(app_rx_done),
    .app_tx_valid(app_tx_valid), .app_tx_rd(app_tx_rd), .app_tx_data(app_tx_data),
    .app_tx_last(app_tx_last), .app_tx_ep(app_tx_ep), .app_tx_abort(app_tx_abort)
  );

  // Receive FIFO contents, IN packet source and capture buffers
  logic [7:0] rx_mem [16];
  logic [7:0] tx_src [16];
  logic [7:0] rx_got [16];
  logic [7:0] tx_got [16];
  int rx_len = 0, tx_len = 0;
  int rx_idx, tx_idx, rx_cnt, tx_cnt, rd_cnt, setup_cnt, done_cnt, abort_cnt, bad_cnt;
  logic mon_clr = 1'b0;

  assign rfifo_empty = (rx_idx >= rx_len);
  assign rfifo_rdata = rx_mem[rx_idx[3:0]];
  assign app_tx_data = tx_src[tx_idx[3:0]];
  assign app_tx_last = (tx_idx == tx_len - 1);

  always @(posedge clk) begin
    if (mon_clr) begin
      rx_idx <= 0; tx_idx <= 0; rx_cnt <= 0; tx_cnt <= 0; rd_cnt <= 0;
      setup_cnt <= 0; done_cnt <= 0; abort_cnt <= 0; bad_cnt <= 0;
    end else begin
      bad_cnt <= bad_cnt + int'(rfifo_rd && rfifo_empty) + int'(tfifo_wr && tfifo_full)
                         + int'(rfifo_rd != app_rx_wr) + int'(tfifo_wr != app_tx_rd);
      if (rfifo_rd) begin
        rx_idx <= rx_idx + 1;
        rd_cnt <= rd_cnt + 1;
      end
      if (app_rx_wr) begin
        rx_got[rx_cnt[3:0]] <= app_rx_data;
        rx_cnt <= rx_cnt + 1;
        if (app_rx_setup) setup_cnt <= setup_cnt + 1;
      end
      if (tfifo_wr) begin
        tx_got[tx_cnt[3:0]] <= tfifo_wdata;
        tx_cnt <= tx_cnt + 1;
      end
      if (app_tx_rd) tx_idx <= tx_idx + 1;
      if (app_rx_done) done_cnt <= done_cnt + 1;
      if (app_tx_abort) abort_cnt <= abort_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Raise req; returns one edge later when the registered reply is valid
  task automatic req_start(input logic [1:0] t, input logic [3:0] e);
    trsac_type = t;
    trsac_ep   = e;
    trsac_req  = 1'b1;
    @(negedge clk);
  endtask

  task automatic req_end();
    trsac_req = 1'b0;
    tick(2);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 60 && rx_cnt < n; i++) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 60 && tx_cnt < n; i++) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rx_mem[i] = 8'h10 + 8'(i);
      tx_src[i] = 8'hA0 + 8'(i);
    end
    clear_mon();
    tick(2);
    chk("rst_reply", 32'(trsac_reply), 32'd3);
    chk("rst_rd", 32'(rfifo_rd), 32'd0);
    chk("rst_wr", 32'(tfifo_wr), 32'd0);
    chk("rst_done", 32'(app_rx_done), 32'd0);
    chk("rst_abort", 32'(app_tx_abort), 32'd0);
    rst1_sync = 1'b0;
    tick(1);

    // SETUP on ep0 is ACKed even with ep0 halted
    ep_stall = 4'b0001;
    rx_len = 8;
    clear_mon();
    req_start(2'd2, 4'd0);
    chk("setup_reply", 32'(trsac_reply), 32'd0);
    wait_rx(8);
    chk("setup_rx_cnt", 32'(rx_cnt), 32'd8);
    chk("setup_flag_cnt", 32'(setup_cnt), 32'd8);
    chk("setup_rx_ep", 32'(app_rx_ep), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("setup_byte%0d", i), 32'(rx_got[i]), 32'(8'h10 + 8'(i)));
    trsac_req = 1'b0;
    @(negedge clk);
    chk("setup_done_pulse", 32'(app_rx_done), 32'd1);
    chk("setup_reply_end", 32'(trsac_reply), 32'd3);
    @(negedge clk);
    chk("setup_done_low", 32'(app_rx_done), 32'd0);
    chk("setup_done_cnt", 32'(done_cnt), 32'd1);
    ep_stall = '0;

    // IN ep2 with a two-cycle full stall mid-packet
    app_tx_valid = 4'b0100;
    tx_len = 4;
    clear_mon();
    req_start(2'd1, 4'd2);
    chk("in2_reply", 32'(trsac_reply), 32'd0);
    wait_tx(2);
    tfifo_full = 1'b1;
    tick(2);
    chk("in2_hold_cnt", 32'(tx_cnt), 32'd2);
    tfifo_full = 1'b0;
    wait_tx(4);
    tick(2);
    chk("in2_tx_cnt", 32'(tx_cnt), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("in2_byte%0d", i), 32'(tx_got[i]), 32'(8'hA0 + 8'(i)));
    chk("in2_tx_ep", 32'(app_tx_ep), 32'd2);
    chk("in2_reply_hold", 32'(trsac_reply), 32'd0);
    trsac_req = 1'b0;
    @(negedge clk);
    chk("in2_reply_end", 32'(trsac_reply), 32'd3);
    @(negedge clk);
    chk("in2_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("in2_bad", 32'(bad_cnt), 32'd0);

    // OUT ep1 NAK / STALL, out-of-range and illegal tokens: no FIFO strobes
    rx_len = 2;
    clear_mon();
    req_start(2'd0, 4'd1);
    chk("out1_nak", 32'(trsac_reply), 32'd1);
    tick(2);
    chk("out1_nak_hold", 32'(trsac_reply), 32'd1);
    req_end();
    ep_stall = 4'b0010;
    req_start(2'd0, 4'd1);
    chk("out1_stall", 32'(trsac_reply), 32'd2);
    req_end();
    ep_stall = '0;
    req_start(2'd0, 4'd5);
    chk("out5_noreply", 32'(trsac_reply), 32'd3);
    req_end();
    req_start(2'd2, 4'd1);
    chk("setup1_noreply", 32'(trsac_reply), 32'd3);
    req_end();
    req_start(2'd3, 4'd0);
    chk("rsvd_noreply", 32'(trsac_reply), 32'd3);
    req_end();
    chk("nak_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("nak_tx_cnt", 32'(tx_cnt), 32'd0);

    // Unconfigured device: only ep0 answers
    device_configured = 1'b0;
    app_tx_valid = 4'b0010;
    req_start(2'd1, 4'd1);
    chk("unconf_in1", 32'(trsac_reply), 32'd3);
    req_end();
    req_start(2'd1, 4'd0);
    chk("unconf_in0_nak", 32'(trsac_reply), 32'd1);
    req_end();
    app_tx_valid = 4'b0001;
    tx_len = 1;
    clear_mon();
    req_start(2'd1, 4'd0);
    chk("unconf_in0_ack", 32'(trsac_reply), 32'd0);
    wait_tx(1);
    req_end();
    chk("unconf_in0_cnt", 32'(tx_cnt), 32'd1);
    chk("unconf_in0_byte", 32'(tx_got[0]), 32'hA0);
    device_configured = 1'b1;

    // IN ep3 abandoned after 2 of 6 bytes
    app_tx_valid = 4'b1000;
    tx_len = 6;
    clear_mon();
    req_start(2'd1, 4'd3);
    chk("in3_reply", 32'(trsac_reply), 32'd0);
    wait_tx(2);
    trsac_req = 1'b0;
    @(negedge clk);
    chk("in3_abort_pulse", 32'(app_tx_abort), 32'd1);
    chk("in3_reply_end", 32'(trsac_reply), 32'd3);
    chk("in3_wr_idle", 32'(tfifo_wr), 32'd0);
    @(negedge clk);
    chk("in3_abort_low", 32'(app_tx_abort), 32'd0);
    chk("in3_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("in3_tx_cnt", 32'(tx_cnt), 32'd2);

    // Reset in the middle of an OUT data phase, then an immediate new token
    app_tx_valid = '0;
    app_rx_ready = 4'b0010;
    rx_len = 8;
    clear_mon();
    req_start(2'd0, 4'd1);
    chk("out1_ack", 32'(trsac_reply), 32'd0);
    wait_rx(3);
    rst1_sync = 1'b1;
    @(negedge clk);
    chk("mid_rst_reply", 32'(trsac_reply), 32'd3);
    chk("mid_rst_rd", 32'(rfifo_rd), 32'd0);
    chk("mid_rst_rx_wr", 32'(app_rx_wr), 32'd0);
    chk("mid_rst_done", 32'(app_rx_done), 32'd0);
    chk("mid_rst_ep", 32'(app_rx_ep), 32'd0);
    trsac_req = 1'b0;
    tick(1);
    chk("mid_rst_no_pop", 32'(rx_cnt), 32'd4);
    rx_len = 2;
    clear_mon();
    rst1_sync = 1'b0;
    req_start(2'd2, 4'd0);
    chk("post_rst_reply", 32'(trsac_reply), 32'd0);
    wait_rx(2);
    chk("post_rst_rx_cnt", 32'(rx_cnt), 32'd2);
    chk("post_rst_byte1", 32'(rx_got[1]), 32'h11);
    req_end();
    chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);
    chk("post_rst_bad", 32'(bad_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
